// File: rtl/bp_be_dcache_lce_cmd_buffer_if.sv
// bp_be_dcache_lce_cmd_buffer_if: network-side ready/valid and LCE-side valid/yumi bundle
// for the LCE command buffer, plus its occupancy, credit and error status.
interface bp_be_dcache_lce_cmd_buffer_if #(
    parameter int els_p       = 4,
    parameter int cmd_width_p = 128
);
    localparam int cw_lp = $clog2(els_p + 1);

    logic [cmd_width_p-1:0] lce_cmd_i;
    logic                   lce_cmd_v_i;
    logic                   lce_cmd_ready_o;
    logic [cmd_width_p-1:0] lce_cmd_o;
    logic                   lce_cmd_v_o;
    logic                   lce_cmd_yumi_i;
    logic [cw_lp-1:0]       count_o;
    logic                   credit_return_o;
    logic                   error_o;

    modport master (
        output lce_cmd_i, lce_cmd_v_i, lce_cmd_yumi_i,
        input  lce_cmd_ready_o, lce_cmd_o, lce_cmd_v_o, count_o, credit_return_o, error_o
    );

    modport slave (
        input  lce_cmd_i, lce_cmd_v_i, lce_cmd_yumi_i,
        output lce_cmd_ready_o, lce_cmd_o, lce_cmd_v_o, count_o, credit_return_o, error_o
    );
endinterface

// File: rtl/bp_be_dcache_lce_cmd_buffer.sv
// bp_be_dcache_lce_cmd_buffer: in-order LCE command FIFO with registered ready and credit return.
// Define BP_BE_DCACHE_LCE_CMD_BYPASS_EN to pass a command straight through an empty buffer.
module bp_be_dcache_lce_cmd_buffer #(
    parameter int els_p       = 4,
    parameter int cmd_width_p = 128
) (
    input logic clk_i,
    input logic reset_n_i,
    bp_be_dcache_lce_cmd_buffer_if.slave io
);
    localparam int pw_lp = $clog2(els_p);
    localparam int cw_lp = $clog2(els_p + 1);

    logic [cmd_width_p-1:0] mem_q [els_p];
    logic [pw_lp-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [cw_lp-1:0]       count_q, count_d;
    logic                   ready_q, credit_q, error_q;
    logic                   empty, byp, enq, deq, wr, rd;

    assign empty = count_q == '0;

`ifdef BP_BE_DCACHE_LCE_CMD_BYPASS_EN
    assign byp          = empty & io.lce_cmd_v_i & ready_q;
    assign io.lce_cmd_v_o = ~empty | byp;
    assign io.lce_cmd_o   = byp ? io.lce_cmd_i : mem_q[rd_ptr_q];
`else
    assign byp          = 1'b0;
    assign io.lce_cmd_v_o = ~empty;
    assign io.lce_cmd_o   = mem_q[rd_ptr_q];
`endif

    assign enq = io.lce_cmd_v_i & ready_q;
    assign deq = io.lce_cmd_yumi_i & io.lce_cmd_v_o;
    // A bypassed command consumed in the same cycle never touches storage.
    assign wr  = enq & ~(byp & deq);
    assign rd  = deq & ~byp;

    assign wr_ptr_d = wr ? (wr_ptr_q == pw_lp'(els_p - 1) ? '0 : wr_ptr_q + pw_lp'(1)) : wr_ptr_q;
    assign rd_ptr_d = rd ? (rd_ptr_q == pw_lp'(els_p - 1) ? '0 : rd_ptr_q + pw_lp'(1)) : rd_ptr_q;
    assign count_d  = (wr & ~rd) ? count_q + cw_lp'(1) : (rd & ~wr) ? count_q - cw_lp'(1) : count_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            credit_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ready_q  <= count_d < cw_lp'(els_p);
            credit_q <= deq;
            error_q  <= error_q | (io.lce_cmd_yumi_i & ~io.lce_cmd_v_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_ptr_q] <= io.lce_cmd_i;
    end

    assign io.lce_cmd_ready_o = ready_q;
    assign io.count_o         = count_q;
    assign io.credit_return_o = credit_q;
    assign io.error_o         = error_q;
endmodule
